// File: rtl/vp_encoder_pp.sv
// Vector-pair encoder: packs valid weight/activation pairs into
// GROUP-lane banks and issues them through an NBUF-deep queue.
module vp_encoder_pp #(
  parameter int W_LEN  = 474,
  parameter int IA_CH  = 8,
  parameter int GROUP  = 3,
  parameter int NBUF   = 2,
  parameter int ADDR_W = 7,
  parameter int DW     = 16,
  parameter int POS_W  = 9
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic [$clog2(W_LEN):0]         i_w_len,
  input  logic                           i_valid_buf [W_LEN],
  input  logic [POS_W-1:0]               i_pos_buf [W_LEN],
  input  logic [2:0][ADDR_W-1:0]         i_addr_buf [W_LEN],
  input  logic signed [DW-1:0]           i_w_data [W_LEN],
  input  logic signed [DW-1:0]           i_ia_data [IA_CH],
  output logic                           o_grp_valid,
  input  logic                           i_grp_ready,
  output logic [2:0][ADDR_W-1:0]         o_grp_addr [GROUP],
  output logic signed [DW-1:0]           o_grp_w [GROUP],
  output logic signed [DW-1:0]           o_grp_ia [GROUP],
  output logic [GROUP-1:0]               o_grp_mask,
  output logic                           o_grp_last,
  output logic                           o_busy,
  output logic                           o_finish,
  output logic                           o_err_pos
);

  localparam int IW = $clog2(W_LEN);
  localparam int LW = IW + 1;
  localparam int KW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int PW = $clog2(NBUF);
  localparam int OW = $clog2(NBUF + 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, FLUSH, DRAIN, DONE
  } state_t;

  state_t state, nxt;

  logic [LW-1:0] idx;
  logic [KW-1:0] k;
  logic [PW-1:0] wp, rp;
  logic [OW-1:0] occ;
  logic          err;

  logic [2:0][ADDR_W-1:0] q_addr [NBUF][GROUP];
  logic signed [DW-1:0]   q_w    [NBUF][GROUP];
  logic signed [DW-1:0]   q_ia   [NBUF][GROUP];
  logic [GROUP-1:0]       q_mask [NBUF];
  logic                   q_last [NBUF];

  logic [IW-1:0]        cur;
  logic [POS_W-1:0]     ent_pos;
  logic signed [DW-1:0] ent_ia;
  logic in_range, ent_valid, pos_bad;
  logic bank_free, pop, stall;
  logic wr_lane, commit_scan, commit;
  logic rest_valid;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cur       = idx[IW-1:0];
    in_range  = idx < i_w_len;
    ent_valid = in_range && i_valid_buf[cur];
    ent_pos   = i_pos_buf[cur];
    pos_bad   = ent_pos >= POS_W'(IA_CH);
    ent_ia    = '0;
    for (int c = 0; c < IA_CH; c++)
      if (ent_pos == POS_W'(c))
        ent_ia = i_ia_data[c];
  end

  // Lookahead so the final full bank can carry last on its own commit.
  always_comb begin
    rest_valid = 1'b0;
    for (int j = 0; j < W_LEN; j++)
      if (i_valid_buf[j] && LW'(j) > idx && LW'(j) < i_w_len)
        rest_valid = 1'b1;
  end

  always_comb begin
    bank_free   = occ < OW'(NBUF);
    pop         = o_grp_valid && i_grp_ready;
    stall       = ent_valid && !bank_free;
    wr_lane     = (state == SCAN) && ent_valid && bank_free;
    commit_scan = wr_lane && (k == KW'(GROUP - 1));
    commit      = commit_scan || ((state == FLUSH) && bank_free);
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (i_start) nxt = SCAN;
      SCAN:  if (!in_range) nxt = (k != '0) ? FLUSH : DRAIN;
      FLUSH: if (bank_free) nxt = DRAIN;
      DRAIN: if (occ == '0 || (occ == OW'(1) && pop)) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      idx   <= '0;
      k     <= '0;
      wp    <= '0;
      rp    <= '0;
      occ   <= '0;
      err   <= 1'b0;
      for (int b = 0; b < NBUF; b++) begin
        q_mask[b] <= '0;
        q_last[b] <= 1'b0;
        for (int l = 0; l < GROUP; l++) begin
          q_addr[b][l] <= '0;
          q_w[b][l]    <= '0;
          q_ia[b][l]   <= '0;
        end
      end
    end else begin
      state <= nxt;
      if (state == IDLE && i_start) begin
        idx <= '0;
        k   <= '0;
        err <= 1'b0;
      end
      if (state == SCAN && in_range && !stall)
        idx <= idx + 1'b1;
      if (wr_lane) begin
        // Opening a bank zeroes every lane so a flushed partial is clean.
        for (int l = 0; l < GROUP; l++) begin
          if (KW'(l) == k) begin
            q_addr[wp][l]    <= i_addr_buf[cur];
            q_w[wp][l]       <= i_w_data[cur];
            q_ia[wp][l]      <= ent_ia;
            q_mask[wp][l]    <= 1'b1;
          end else if (k == '0) begin
            q_addr[wp][l]    <= '0;
            q_w[wp][l]       <= '0;
            q_ia[wp][l]      <= '0;
            q_mask[wp][l]    <= 1'b0;
          end
        end
        k <= commit_scan ? '0 : k + 1'b1;
        if (pos_bad)
          err <= 1'b1;
      end
      if (commit_scan)
        q_last[wp] <= !rest_valid;
      if (state == FLUSH && bank_free) begin
        q_last[wp] <= 1'b1;
        k          <= '0;
      end
      if (commit)
        wp <= inc(wp);
      if (pop)
        rp <= inc(rp);
      occ <= occ + OW'(commit) - OW'(pop);
    end
  end

  assign o_grp_valid = occ != '0;
  assign o_grp_addr  = q_addr[rp];
  assign o_grp_w     = q_w[rp];
  assign o_grp_ia    = q_ia[rp];
  assign o_grp_mask  = q_mask[rp];
  assign o_grp_last  = q_last[rp];
  assign o_busy      = state != IDLE;
  assign o_finish    = state == DONE;
  assign o_err_pos   = err;

endmodule

// File: doc/vp_encoder_pp.md
# vp_encoder_pp

Parametrised vector-pair encoder for the sparse convolution datapath. It scans a compressed weight-column buffer one entry per cycle and skips invalid entries. Each valid weight is paired with the input-activation channel selected by its position index. Pairs are packed into fixed-size groups, held in an NBUF-deep bank queue, and issued to the PE array over a valid/ready handshake. This block replaces the fixed 3-wide left/right ping-pong encoder; it adds backpressure, partial-group flush with lane mask, last-group marking and position-range error reporting.

## Interface
- W_LEN, 474: max weight entries per column
- IA_CH, 8: activation channels
- GROUP, 3: lanes per output group
- NBUF, 2: group banks in queue (≥2)
- ADDR_W, 7: width of each of the 3 address fields
- DW, 16: signed data width
- POS_W, 9: position index width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  start pulse, accepted only in IDLE
- i_w_len  in  $clog2(W_LEN)+1  entries to scan
- i_valid_buf  in  [W_LEN]×1  entry valid
- i_pos_buf  in  [W_LEN]×POS_W  activation channel index
- i_addr_buf  in  [W_LEN]×3×ADDR_W  output address triple
- i_w_data  in  [W_LEN]×DW signed  weights
- i_ia_data  in  [IA_CH]×DW signed  activations
- o_grp_valid  out  1  head group available
- i_grp_ready  in  1  consumer accepts head group
- o_grp_addr / o_grp_w / o_grp_ia  out  [GROUP]× (3×ADDR_W / DW / DW)  lane payload
- o_grp_mask  out  GROUP  lane occupied
- o_grp_last  out  1  head group is final group of job
- o_busy  out  1  state ≠ IDLE
- o_finish  out  1  one-cycle job-complete pulse
- o_err_pos  out  1  sticky: some valid entry had pos ≥ IA_CH

## Operation
- States: IDLE, SCAN, FLUSH, DRAIN, DONE.
- IDLE: i_start=1 → SCAN. On that edge: idx=0, slot k=0, o_err_pos cleared.
- Inputs are held stable by the producer from start until o_finish.
- SCAN, idx<i_w_len, fill bank free:
  - If valid[idx], write lane k with addr[idx], w[idx] and ia = (pos<IA_CH ? i_ia_data[pos] : 0). Set mask[k]=1.
  - pos ≥ IA_CH sets o_err_pos.
  - When k reaches GROUP-1, the bank is committed and k returns to 0.
  - idx increments every cycle in which SCAN is not stalled.
- SCAN stall: all NBUF banks are occupied while a write is pending. idx and k hold; no entry is lost.
- SCAN, idx==i_w_len:
  - k>0 → FLUSH. Unused lanes are zero: addr, w, ia = 0 and mask = 0.
  - k==0 → DRAIN. The most recently committed bank gets last=1 when it is committed.
- FLUSH: commits the partial bank with last=1 when a bank is free, then → DRAIN.
- DRAIN: → DONE when occupancy==0, or occupancy==1 with a handshake this cycle.
- DONE: o_finish=1 for one cycle, then → IDLE.
- Queue behaviour:
  - FIFO order.
  - Handshake = o_grp_valid & i_grp_ready.
  - A freed bank is writable from the next cycle.
  - Commit and pop in the same cycle leave occupancy unchanged.
- i_start outside IDLE is ignored.

## Timing
- Reset (async, i_rst=1):
  - State IDLE.
  - Occupancy, idx and k = 0.
  - All outputs 0, including payload, mask, last, busy, finish and err_pos.
- Reset mid-job aborts the job; queued groups are discarded.
- Call the start edge E0. Each scanned entry is processed on a later edge E1, E2, …
- A group is visible on o_grp_valid in the cycle after the edge that writes its last lane.
- Without stall: first o_grp_valid = (index of GROUP-th valid entry)+1 cycles after E0.
- o_grp_* are registered and stable while o_grp_valid=1 and i_grp_ready=0.
- i_w_len=0: E1 → DRAIN, E2 → DONE. o_finish is high in the cycle after E2; no group is issued.
- Throughput: one entry per cycle, one group per cycle on output.

## Test plan
- Baseline (GROUP=3, i_grp_ready=1):
  - Stimulus: len=10, valid={0,0,0,0,1,1,1,1,1,1}, pos={1,1,7,1,6,5,4,1,1,3}, w[i]=i, addr[i]=(i,i,i), ia[c]=c.
  - Group 0: w=4,5,6, ia=6,5,4, mask=111, last=0; o_grp_valid first high 7 cycles after E0.
  - Group 1: w=7,8,9, ia=1,1,3, mask=111, last=1.
  - Then o_finish pulse; err_pos=0.
- Partial flush: same stimulus with valid only at idx 4..7.
  - Group 1: w=7,0,0, ia=1,0,0, addr lanes 1–2 = 0, mask=001, last=1.
- Backpressure: ready=0 for 20 cycles, 12 consecutive valid entries.
  - Scan stalls after NBUF=2 groups are committed.
  - After ready=1, all 4 groups arrive in order with w 0..11; payload is stable while held.
- Position error: pos[4]=9 with IA_CH=8.
  - That lane gets ia=0 and w=4; o_err_pos=1 until the next i_start.
- Reset mid-job: assert i_rst while o_grp_valid=1 with one group queued.
  - All outputs go to 0 immediately (asynchronous).
  - A new start runs baseline correctly with no stale groups.
- Zero length / ignored start:
  - len=0 → o_finish in the cycle after E2, no o_grp_valid.
  - i_start pulsed during SCAN has no effect.
